// File: rtl/array_types_pkg.sv
// Shared types for the cache data/metadata array and its flush walker.
package array_types_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } flush_state_t;

endpackage

// File: rtl/array_bank.sv
// DEPTH x WIDTH byte-enabled line storage with per-entry valid/dirty bits,
// a combinational read port at rd_index and a second read port at ptr.
module array_bank
    import array_types_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IDX_W-1:0]   rd_index,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               wr_en,
    input  logic [WIDTH/8-1:0] byte_en,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               set_dirty,
    input  logic               inval_en,
    input  logic               clean_en,
    output logic [WIDTH-1:0]   rd_data,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [WIDTH-1:0]   ptr_data,
    output logic               ptr_valid,
    output logic               ptr_dirty
);

    localparam int NBYTES = WIDTH / 8;

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] dirty_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                data_q[e] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (byte_en[b]) begin
                    data_q[rd_index][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Invalidate beats a same-cycle write on the metadata; the data is still
    // written. clean_en only fires while the walker owns the array, so it
    // never collides with a write or invalidate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (inval_en) begin
                valid_q[rd_index] <= 1'b0;
                dirty_q[rd_index] <= 1'b0;
            end else if (wr_en) begin
                valid_q[rd_index] <= 1'b1;
                if (set_dirty) begin
                    dirty_q[rd_index] <= 1'b1;
                end
            end
            if (clean_en) begin
                dirty_q[ptr] <= 1'b0;
            end
        end
    end

    assign rd_data   = data_q[rd_index];
    assign rd_valid  = valid_q[rd_index];
    assign rd_dirty  = dirty_q[rd_index];
    assign ptr_data  = data_q[ptr];
    assign ptr_valid = valid_q[ptr];
    assign ptr_dirty = dirty_q[ptr];

endmodule

// File: rtl/flush_array.sv
// Cache data/metadata array with a flush walker that streams dirty lines to
// the writeback path over a valid/ready handshake.
//
//   state | meaning
//   IDLE  | array open to controller reads/writes/invalidates
//   SCAN  | inspect entry[ptr]; one entry per cycle
//   WB    | present entry[ptr] on wb_*, hold until wb_ready
//   DONE  | one-cycle flush_done pulse, then back to IDLE
module flush_array
    import array_types_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IDX_W-1:0]   index,
    input  logic               write,
    input  logic [WIDTH/8-1:0] byte_en,
    input  logic [WIDTH-1:0]   datain,
    input  logic               set_dirty,
    input  logic               invalidate,
    output logic [WIDTH-1:0]   dataout,
    output logic               valid_out,
    output logic               dirty_out,
    input  logic               flush_req,
    output logic               flush_busy,
    output logic               wb_valid,
    output logic [IDX_W-1:0]   wb_index,
    output logic [WIDTH-1:0]   wb_data,
    input  logic               wb_ready,
    output logic               flush_done
);

    flush_state_t     state_q;
    flush_state_t     state_d;
    logic [IDX_W-1:0] ptr_q;
    logic             ptr_clr;
    logic             ptr_inc;
    logic             ptr_last;
    logic             clean_en;
    logic             wr_en;
    logic             inval_en;
    logic [WIDTH-1:0] ptr_data;
    logic             ptr_valid;
    logic             ptr_dirty;

    assign flush_busy = (state_q != IDLE);
    assign wr_en      = write      & ~flush_busy;
    assign inval_en   = invalidate & ~flush_busy;
    assign ptr_last   = (ptr_q == IDX_W'(DEPTH - 1));

    array_bank #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (index),
        .ptr       (ptr_q),
        .wr_en     (wr_en),
        .byte_en   (byte_en),
        .wr_data   (datain),
        .set_dirty (set_dirty),
        .inval_en  (inval_en),
        .clean_en  (clean_en),
        .rd_data   (dataout),
        .rd_valid  (valid_out),
        .rd_dirty  (dirty_out),
        .ptr_data  (ptr_data),
        .ptr_valid (ptr_valid),
        .ptr_dirty (ptr_dirty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (ptr_clr) begin
                ptr_q <= '0;
            end else if (ptr_inc) begin
                ptr_q <= ptr_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_clr    = 1'b0;
        ptr_inc    = 1'b0;
        clean_en   = 1'b0;
        wb_valid   = 1'b0;
        flush_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = SCAN;
                    ptr_clr = 1'b1;
                end
            end
            SCAN: begin
                if (ptr_valid && ptr_dirty) begin
                    state_d = WB;
                end else if (ptr_last) begin
                    state_d = DONE;
                end else begin
                    ptr_inc = 1'b1;
                end
            end
            WB: begin
                wb_valid = 1'b1;
                if (wb_ready) begin
                    clean_en = 1'b1;
                    if (ptr_last) begin
                        state_d = DONE;
                    end else begin
                        ptr_inc = 1'b1;
                        state_d = SCAN;
                    end
                end
            end
            DONE: begin
                flush_done = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ptr only moves inside the walker, so wb_* stays stable while stalled.
    assign wb_index = ptr_q;
    assign wb_data  = ptr_data;

endmodule
